xc_sha3_unindex: RTL and testbench
==================================

Name: xc_sha3_unindex

Overview:
- Multi-cycle inverse of the sha3 lane-indexing functions: takes a scaled lane address and recovers the (x, y) lane coordinates that would produce it under xy, x1/x2/x4 or yx indexing.
- Sits beside the sha3 indexing unit in the crypto execute stage; used by debug/trace and by software state-walk helpers.
- Division by 5 is iterative (subtract-5), not a LUT, to keep area minimal.
- Valid/ready handshake on both sides.

Parameters:
- none (widths fixed by the ISA: 32-bit operands, 25-lane state)

Ports:
- g_clk  input  1  clock; all state updates on rising edge
- g_reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- rs1  input  32  scaled lane address
- shamt  input  2  scale shift: index = rs1 >> shamt
- f_xy  input  1  inverse of xy indexing (one-hot group)
- f_x1  input  1  inverse of x+1 indexing
- f_x2  input  1  inverse of x+2 indexing
- f_x4  input  1  inverse of x+4 indexing
- f_yx  input  1  inverse of yx (rho/pi) indexing
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  32  {21'b0, y[2:0], 5'b0, x[2:0]}: x in [2:0], y in [10:8]
- err  output  1  request rejected (misaligned or out of range); qualifies result

Behaviour:
- Reset (async, any state): state=IDLE; out_valid=0; result=0; err=0; internal q/r/func regs cleared.
- in_ready = (state==IDLE) && !g_reset.
- Accept when in_valid && in_ready. Latch the f_* select, compute idx = rs1 >> shamt, q=0, r=idx[4:0].
- Misaligned when rs1 & ((1<<shamt)-1) != 0. Out of range when idx >= 25 (full 32-bit compare). Either condition: go to DONE with err=1, result=0.
- Otherwise go to DIV.
- f_* must be one-hot at accept. All zero or more than one set: err=1, result=0.
- DIV: each cycle, if r>=5 then r<=r-5, q<=q+1, stay in DIV; else go to MAP. DIV occupies floor(idx/5)+1 cycles (1..5).
- MAP (1 cycle): with X'=r and Y'=q, produce (x, y) and go to DONE with err=0.
  - f_xy: x=X', y=Y'.
  - f_x1/f_x2/f_x4 with k=1/2/4: x=(X'+5-k) mod 5, y=Y'.
  - f_yx: y=X', x=(3*(Y'+2*X')) mod 5. Intermediate is 6 bits unsigned, max 36.
- DONE: out_valid=1. result and err held stable until out_ready. On out_valid && out_ready, out_valid<=0 and state<=IDLE in the same edge.
- Next request is accepted no earlier than the cycle after return to IDLE (no overlap).
- Latency accept->out_valid: 2 + floor(idx/5) cycles for valid requests; 1 cycle for err requests.
- rs1/shamt/f_* may change after accept without effect.
- in_valid in non-IDLE states is ignored (in_ready=0).
- Reset mid-DIV or mid-DONE: request discarded; out_valid drops immediately.
- Outputs are always within range: x,y in 0..4 whenever err=0.

Test Plan:
- f_xy, rs1=0x17, shamt=0 -> after 6 cycles out_valid=1, x=3, y=4, err=0 (5 DIV cycles).
- f_yx, rs1=0x88, shamt=3 (idx 17) -> x=1, y=2, err=0; idx=0 -> x=0, y=0 in 2 cycles.
- f_x4, rs1=7, shamt=0 -> x=3, y=1. Sweep all 25 idx for every function: applying the forward sha3 index to the output must reproduce idx.
- Errors: rs1=25 -> err=1, result=0, 1-cycle latency. rs1=0x89, shamt=3 -> err=1. f_x1 and f_x2 both set -> err=1.
- Backpressure: out_ready held 0 for 10 cycles -> result/err stable, in_ready=0, new in_valid ignored. Release -> next accept the cycle after the handshake.
- g_reset pulsed mid-DIV (idx 24) -> out_valid=0 and result=0 asynchronously; after release in_ready=1 and a fresh request completes correctly.

Source files
------------

// File: rtl/xc_sha3_unindex_if.sv
// xc_sha3_unindex_if: request/response bundle for the sha3 lane un-indexing unit.
//   Request side : in_valid, in_ready, rs1[31:0], shamt[1:0], f_xy/f_x1/f_x2/f_x4/f_yx
//   Response side: out_valid, out_ready, result[31:0], err
// master = requester (drives the request, consumes the response); slave = the unit.
interface xc_sha3_unindex_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [1:0]  shamt;
    logic        f_xy;
    logic        f_x1;
    logic        f_x2;
    logic        f_x4;
    logic        f_yx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        err;

    modport master (
        output in_valid, rs1, shamt, f_xy, f_x1, f_x2, f_x4, f_yx, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, rs1, shamt, f_xy, f_x1, f_x2, f_x4, f_yx, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/xc_sha3_unindex.sv
// xc_sha3_unindex: recovers sha3 lane coordinates (x, y) from a scaled lane address,
// inverting xy, x+1/x+2/x+4 or yx (rho/pi) indexing. idx = rs1 >> shamt is divided by 5
// with a subtract-5 loop (quotient Y', remainder X'), then mapped back to (x, y).
// Ports:
//   g_clk   : clock, rising edge
//   g_reset : asynchronous active-high reset
//   bus     : xc_sha3_unindex_if.slave
//             result = {21'b0, y[2:0], 5'b0, x[2:0]}; err flags a rejected request
//             (misaligned rs1, idx >= 25, or function select not one-hot).
module xc_sha3_unindex (
    input  logic                     g_clk,
    input  logic                     g_reset,
    xc_sha3_unindex_if.slave         bus
);

    typedef enum logic [1:0] {StIdle, StDiv, StMap, StDone} state_t;

    state_t      state;
    logic [2:0]  quo;
    logic [4:0]  rem;
    logic [4:0]  func;      // {xy, x1, x2, x4, yx}
    logic        bad;
    logic        valid_r;
    logic [31:0] result_r;
    logic        err_r;

    logic [31:0] idx;
    logic [31:0] low_mask;
    logic        req_bad;
    logic [4:0]  f_sel;

    logic [3:0]  x_sum;
    logic [5:0]  yx_lin;
    logic [5:0]  yx_sum;
    logic [2:0]  map_x;
    logic [2:0]  map_y;

    assign f_sel    = {bus.f_xy, bus.f_x1, bus.f_x2, bus.f_x4, bus.f_yx};
    assign idx      = bus.rs1 >> bus.shamt;
    assign low_mask = (32'd1 << bus.shamt) - 32'd1;
    assign req_bad  = ((bus.rs1 & low_mask) != 32'd0) || (idx >= 32'd25) || !$onehot(f_sel);

    assign bus.in_ready  = (state == StIdle) && !g_reset;
    assign bus.out_valid = valid_r;
    assign bus.result    = result_r;
    assign bus.err       = err_r;

    // Inverse mapping; only meaningful in StMap, where rem < 5 and quo < 5.
    always_comb begin
        x_sum  = 4'd0;
        yx_lin = 6'd0;
        yx_sum = 6'd0;
        map_x  = rem[2:0];
        map_y  = quo;
        case (1'b1)
            func[3]: x_sum = {1'b0, rem[2:0]} + 4'd4;   // x1: X' - 1 mod 5
            func[2]: x_sum = {1'b0, rem[2:0]} + 4'd3;   // x2: X' - 2 mod 5
            func[1]: x_sum = {1'b0, rem[2:0]} + 4'd1;   // x4: X' - 4 mod 5
            default: x_sum = 4'd0;
        endcase
        if (func[3] || func[2] || func[1]) begin
            map_x = (x_sum >= 4'd5) ? 3'(x_sum - 4'd5) : x_sum[2:0];
        end
        if (func[0]) begin
            // x = 3*(Y' + 2X') mod 5, at most 36 before the reduction
            yx_lin = {3'b000, quo} + {2'b00, rem[2:0], 1'b0};
            yx_sum = yx_lin + {yx_lin[4:0], 1'b0};
            map_x  = 3'(yx_sum % 6'd5);
            map_y  = rem[2:0];
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state    <= StIdle;
            quo      <= 3'd0;
            rem      <= 5'd0;
            func     <= 5'd0;
            bad      <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= 32'd0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        func <= f_sel;
                        quo  <= 3'd0;
                        rem  <= idx[4:0];
                        bad  <= req_bad;
                        // Rejected requests skip the divider and resolve through StMap.
                        state <= req_bad ? StMap : StDiv;
                    end
                end
                StDiv: begin
                    if (rem >= 5'd5) begin
                        rem <= rem - 5'd5;
                        quo <= quo + 3'd1;
                    end else begin
                        state <= StMap;
                    end
                end
                StMap: begin
                    valid_r <= 1'b1;
                    err_r   <= bad;
                    result_r <= bad ? 32'd0 : {21'd0, map_y, 5'd0, map_x};
                    state   <= StDone;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        valid_r <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_xc_sha3_unindex.sv
module tb_xc_sha3_unindex;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    logic g_clk;
    logic g_reset;
    xc_sha3_unindex_if bus();

    xc_sha3_unindex dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
        end
    endtask

    // Forward sha3 lane index; fn: 0=xy 1=x1 2=x2 3=x4 4=yx
    function automatic int fwd(input int fn, input int x, input int y);
        case (fn)
            0: return x + 5 * y;
            1: return ((x + 1) % 5) + 5 * y;
            2: return ((x + 2) % 5) + 5 * y;
            3: return ((x + 4) % 5) + 5 * y;
            default: return y + 5 * ((2 * x + 3 * y) % 5);
        endcase
    endfunction

    // Expected result found by searching the forward map, not by inverting it.
    function automatic logic [31:0] expect_res(input int fn, input int idx);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                if (fwd(fn, x, y) == idx) return (32'(y) << 8) | 32'(x);
        return 32'hdead_beef;
    endfunction

    function automatic logic [4:0] fsel(input int fn);
        logic [4:0] top;
        top = 5'b10000;
        return top >> fn;
    endfunction

    task automatic drive_f(input logic [4:0] f);
        {bus.f_xy, bus.f_x1, bus.f_x2, bus.f_x4, bus.f_yx} = f;
    endtask

    // Present one request and let it be accepted; inputs are scrambled afterwards.
    task automatic send(input logic [31:0] rs1, input logic [1:0] sh, input logic [4:0] f);
        @(negedge g_clk);
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.rs1      = rs1;
        bus.shamt    = sh;
        drive_f(f);
        @(posedge g_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.rs1      = $urandom;
        bus.shamt    = 2'($urandom_range(0, 3));
        drive_f(5'($urandom));
    endtask

    task automatic wait_out(input string tag);
        exp_t e;
        int   lat;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge g_clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        if (!bus.out_valid) begin
            check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
        end else begin
            check({tag, "_result"}, bus.result, e.res);
            check({tag, "_err"}, 32'(bus.err), 32'(e.err));
            check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        end
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge g_clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_req(input string tag, input logic [31:0] rs1, input logic [1:0] sh,
                          input logic [4:0] f, input logic [31:0] res, input logic err,
                          input int lat);
        exp_t e;
        e.res = res;
        e.err = err;
        e.lat = lat;
        sb.push_back(e);
        send(rs1, sh, f);
        wait_out(tag);
        handshake(tag);
    endtask

    initial begin
        logic [31:0] hold_res;
        int sh;

        g_reset       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.rs1       = 32'd0;
        bus.shamt     = 2'd0;
        drive_f(5'd0);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(negedge g_clk);
        @(negedge g_clk);
        g_reset = 1'b0;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed cases
        do_req("xy_17", 32'h17, 2'd0, fsel(0), 32'h0000_0403, 1'b0, 6);
        do_req("yx_88", 32'h88, 2'd3, fsel(4), 32'h0000_0201, 1'b0, 5);
        do_req("yx_0",  32'h0,  2'd0, fsel(4), 32'h0000_0000, 1'b0, 2);
        do_req("x4_7",  32'h7,  2'd0, fsel(3), 32'h0000_0103, 1'b0, 3);

        // Full sweep, round-tripped against the forward index
        for (int fn = 0; fn < 5; fn++) begin
            for (int i = 0; i < 25; i++) begin
                sh = $urandom_range(0, 3);
                do_req($sformatf("sweep_f%0d_i%0d", fn, i), 32'(i) << sh, 2'(sh), fsel(fn),
                       expect_res(fn, i), 1'b0, 2 + i / 5);
            end
        end

        // Rejected requests
        do_req("err_range25", 32'd25, 2'd0, fsel(0), 32'd0, 1'b1, 1);
        do_req("err_misalign", 32'h89, 2'd3, fsel(0), 32'd0, 1'b1, 1);
        do_req("err_two_hot", 32'd3, 2'd0, fsel(1) | fsel(2), 32'd0, 1'b1, 1);
        do_req("err_zero_hot", 32'd3, 2'd0, 5'd0, 32'd0, 1'b1, 1);
        do_req("err_big_idx", 32'h8000_0003, 2'd0, fsel(0), 32'd0, 1'b1, 1);
        do_req("ok_after_err", 32'd24, 2'd0, fsel(0), 32'h0000_0404, 1'b0, 6);

        // Backpressure: hold the result while a new request is offered
        hold_res = expect_res(2, 13);
        sb.push_back('{res: hold_res, err: 1'b0, lat: 4});
        send(32'd13 << 2, 2'd2, fsel(2));
        wait_out("bp");
        @(negedge g_clk);
        bus.in_valid = 1'b1;
        bus.rs1      = 32'd1;
        bus.shamt    = 2'd0;
        drive_f(fsel(0));
        for (int c = 0; c < 10; c++) begin
            @(posedge g_clk);
            #1;
            check($sformatf("bp_valid_c%0d", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_result_c%0d", c), bus.result, hold_res);
            check($sformatf("bp_err_c%0d", c), 32'(bus.err), 32'd0);
            check($sformatf("bp_in_ready_c%0d", c), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        handshake("bp");
        do_req("after_bp", 32'd9, 2'd0, fsel(1), expect_res(1, 9), 1'b0, 3);

        // Reset mid-DIV
        send(32'd24, 2'd0, fsel(0));
        @(posedge g_clk);
        #1;
        @(posedge g_clk);
        #2;
        g_reset = 1'b1;
        #1;
        check("rst_div_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_div_result", bus.result, 32'd0);
        check("rst_div_in_ready", 32'(bus.in_ready), 32'd0);
        #1;
        g_reset = 1'b0;
        #1;
        check("rst_div_in_ready_after", 32'(bus.in_ready), 32'd1);
        do_req("after_rst_div", 32'd24, 2'd0, fsel(0), 32'h0000_0404, 1'b0, 6);

        // Reset while a result is waiting
        send(32'd12, 2'd0, fsel(4));
        for (int c = 0; c < 4; c++) begin
            @(posedge g_clk);
            #1;
        end
        check("rst_done_pre_valid", 32'(bus.out_valid), 32'd1);
        #1;
        g_reset = 1'b1;
        #1;
        check("rst_done_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_done_result", bus.result, 32'd0);
        check("rst_done_err", 32'(bus.err), 32'd0);
        #1;
        g_reset = 1'b0;
        #1;
        check("rst_done_in_ready_after", 32'(bus.in_ready), 32'd1);
        do_req("after_rst_done", 32'd12, 2'd0, fsel(4), expect_res(4, 12), 1'b0, 4);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
